sequence_player: RTL and testbench

- Transmit-side counterpart of the sequence producer.
- Accepts one 10-bit encoded Morse sequence (up to five 2-bit symbols, MSB pair first) plus its Space/EndSeq flag.
- Replays it as a timed on/off key signal using standard Morse timing: dot = 1 unit on, dash = 3 units on, 1 unit off between elements, 3 units off after a letter, 7 units off after a word.
- Sits between the sequence buffer/host and the key driver (LED/buzzer).

---
 rtl/morse_pkg.sv | 40 ++++
 rtl/morse_unit_timer.sv | 49 ++++
 rtl/sequence_player.sv | 119 +++++++++++
 tb/tb_sequence_player.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared Morse symbol/signal codes, timing constants and player state type.
package morse_pkg;

    // 2-bit symbol codes as packed into EncSeq, MSB pair first
    localparam logic [1:0] SYM_DOT  = 2'b00;
    localparam logic [1:0] SYM_DASH = 2'b01;
    localparam logic [1:0] SYM_RSVD = 2'b10;
    localparam logic [1:0] SYM_NONE = 2'b11;

    // Signal codes shared with the sequence producer
    localparam logic [2:0] SIG_DOT    = 3'b000;
    localparam logic [2:0] SIG_DASH   = 3'b001;
    localparam logic [2:0] SIG_SPACE  = 3'b010;
    localparam logic [2:0] SIG_ENDSEQ = 3'b011;

    // Durations in Morse units
    localparam logic [2:0] DOT_UNITS  = 3'd1;
    localparam logic [2:0] DASH_UNITS = 3'd3;
    localparam logic [2:0] ELEM_GAP   = 3'd1;
    localparam logic [2:0] LETTER_GAP = 3'd3;
    localparam logic [2:0] WORD_GAP   = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StMark,
        StGap,
        StTail
    } player_state_t;

    // True for symbols that produce a mark (dot or dash)
    function automatic logic is_mark(input logic [1:0] sym);
        return (sym == SYM_DOT) || (sym == SYM_DASH);
    endfunction

    // Mark length of a dot/dash symbol
    function automatic logic [2:0] mark_units(input logic [1:0] sym);
        return (sym == SYM_DASH) ? DASH_UNITS : DOT_UNITS;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Loadable down-counter: expire_o is high during the last cycle of
// units_i * UNIT_CYCLES cycles following a start_i edge.
module morse_unit_timer
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [2:0] units_i,
    output logic       expire_o
);

    localparam int unsigned CycW = $clog2(UNIT_CYCLES) + 1;
    localparam logic [CycW-1:0] CycLast = CycW'(UNIT_CYCLES - 1);

    logic [CycW-1:0] cyc_q, cyc_d;
    logic [2:0]      unit_q, unit_d;

    // Reload on start, otherwise count cycles within a unit, then units; hold at zero
    always_comb begin
        cyc_d  = cyc_q;
        unit_d = unit_q;
        if (start_i) begin
            cyc_d  = CycLast;
            unit_d = units_i - 3'd1;
        end else if (cyc_q != '0) begin
            cyc_d = cyc_q - 1'b1;
        end else if (unit_q != '0) begin
            cyc_d  = CycLast;
            unit_d = unit_q - 3'd1;
        end
    end

    // Counter registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cyc_q  <= '0;
            unit_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            unit_q <= unit_d;
        end
    end

    assign expire_o = (cyc_q == '0) && (unit_q == '0);

endmodule

// File: rtl/sequence_player.sv
// Replays one encoded Morse sequence as a timed on/off key signal.
module sequence_player
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 2
) (
    input  logic       Clock,
    input  logic       Resetbar,
    input  logic [9:0] EncSeq,
    input  logic       Space_EndSeqbar,
    input  logic       Load,
    output logic       Ready,
    output logic       KeyOut,
    output logic       Done
);

    player_state_t state_q, state_d;
    logic [9:0]    seq_q, seq_d;
    logic          word_q, word_d;
    logic [2:0]    idx_q, idx_d;
    logic          done_q, done_d;

    logic          tmr_start;
    logic [2:0]    tmr_units;
    logic          tmr_expire;

    morse_unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_timer (
        .clk_i   (Clock),
        .rst_ni  (Resetbar),
        .start_i (tmr_start),
        .units_i (tmr_units),
        .expire_o(tmr_expire)
    );

    // Next-state: the current symbol always sits in seq_q[9:8]; the register
    // shifts left one pair per element gap, filling with empty symbols.
    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        word_d    = word_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        tmr_start = 1'b0;
        tmr_units = DOT_UNITS;
        unique case (state_q)
            StIdle: begin
                if (Load) begin
                    seq_d     = EncSeq;
                    word_d    = Space_EndSeqbar;
                    idx_d     = 3'd0;
                    tmr_start = 1'b1;
                    if (is_mark(EncSeq[9:8])) begin
                        state_d   = StMark;
                        tmr_units = mark_units(EncSeq[9:8]);
                    end else begin
                        state_d   = StTail;
                        tmr_units = Space_EndSeqbar ? WORD_GAP : LETTER_GAP;
                    end
                end
            end
            StMark: begin
                if (tmr_expire) begin
                    tmr_start = 1'b1;
                    if (idx_q != 3'd4 && is_mark(seq_q[7:6])) begin
                        state_d   = StGap;
                        tmr_units = ELEM_GAP;
                        seq_d     = {seq_q[7:0], SYM_NONE};
                        idx_d     = idx_q + 3'd1;
                    end else begin
                        // Tail already covers the gap after the last element
                        state_d   = StTail;
                        tmr_units = word_q ? WORD_GAP : LETTER_GAP;
                    end
                end
            end
            StGap: begin
                if (tmr_expire) begin
                    state_d   = StMark;
                    tmr_start = 1'b1;
                    tmr_units = mark_units(seq_q[9:8]);
                end
            end
            StTail: begin
                if (tmr_expire) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset also suppresses a pending Done
    always_ff @(posedge Clock) begin
        if (!Resetbar) begin
            state_q <= StIdle;
            seq_q   <= '0;
            word_q  <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        Ready  = (state_q == StIdle);
        KeyOut = (state_q == StMark);
        Done   = done_q;
    end

endmodule

// File: tb/tb_sequence_player.sv
module tb_sequence_player;

    logic       clk;
    logic       rst_n;
    logic [9:0] enc_seq;
    logic       space_flag;
    logic       load;
    logic       ready;
    logic       key_out;
    logic       done;

    typedef struct {
        string name;
        logic  ready;
        logic  key;
        logic  done;
    } frame_t;

    frame_t exp_q[$];
    int     checks = 0;
    int     errors = 0;

    sequence_player #(
        .UNIT_CYCLES(2)
    ) dut (
        .Clock          (clk),
        .Resetbar       (rst_n),
        .EncSeq         (enc_seq),
        .Space_EndSeqbar(space_flag),
        .Load           (load),
        .Ready          (ready),
        .KeyOut         (key_out),
        .Done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for n consecutive cycles
    task automatic push(input string name, input logic r, input logic k, input logic d,
                        input int n);
        frame_t f;
        f.name  = name;
        f.ready = r;
        f.key   = k;
        f.done  = d;
        for (int i = 0; i < n; i++) exp_q.push_back(f);
    endtask

    task automatic push_done(input string name);
        push(name, 1'b1, 1'b0, 1'b1, 1);
        push(name, 1'b1, 1'b0, 1'b0, 1);
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 after the accept edge
    task automatic issue(input logic [9:0] enc, input logic flag);
        enc_seq    = enc;
        space_flag = flag;
        load       = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, %0d expected cycles still pending, required 0",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: compare one expected frame per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            frame_t f;
            f = exp_q.pop_front();
            checks++;
            if (ready !== f.ready || key_out !== f.key || done !== f.done) begin
                errors++;
                $display("FAIL %s @%0t: got ready=%b key=%b done=%b, required ready=%b key=%b done=%b",
                         f.name, $time, ready, key_out, done, f.ready, f.key, f.done);
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        load       = 1'b0;
        enc_seq    = '0;
        space_flag = 1'b0;

        // Reset state, held and after release
        @(posedge clk);
        #1;
        push("reset", 1'b1, 1'b0, 1'b0, 4);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drain("reset");

        // "A" with letter gap; next Load lands in the Done cycle
        issue(10'b0001111111, 1'b0);
        push("a_letter", 1'b0, 1'b1, 1'b0, 2);
        push("a_letter", 1'b0, 1'b0, 1'b0, 2);
        push("a_letter", 1'b0, 1'b1, 1'b0, 6);
        push("a_letter", 1'b0, 1'b0, 1'b0, 6);
        push("a_letter", 1'b1, 1'b0, 1'b1, 1);
        repeat (16) @(posedge clk);
        #1;

        // "A" with word gap, accepted in the Done cycle
        issue(10'b0001111111, 1'b1);
        push("a_word", 1'b0, 1'b1, 1'b0, 2);
        push("a_word", 1'b0, 1'b0, 1'b0, 2);
        push("a_word", 1'b0, 1'b1, 1'b0, 6);
        push("a_word", 1'b0, 1'b0, 1'b0, 14);
        push_done("a_word");
        drain("a_word");

        // Five dashes; a Load with different data mid-playback must be ignored
        issue(10'b0101010101, 1'b0);
        for (int i = 0; i < 5; i++) begin
            push("full_word", 1'b0, 1'b1, 1'b0, 6);
            if (i < 4) push("full_word", 1'b0, 1'b0, 1'b0, 2);
        end
        push("full_word", 1'b0, 1'b0, 1'b0, 6);
        push_done("full_word");
        repeat (10) @(posedge clk);
        #1;
        enc_seq    = 10'b0000000000;
        space_flag = 1'b1;
        load       = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        drain("full_word");

        // Empty sequence, word gap only
        issue(10'b1111111111, 1'b1);
        push("empty", 1'b0, 1'b0, 1'b0, 14);
        push_done("empty");
        drain("empty");

        // Reserved pair terminates; the trailing dot is never played
        issue(10'b0010001111, 1'b0);
        push("terminate", 1'b0, 1'b1, 1'b0, 2);
        push("terminate", 1'b0, 1'b0, 1'b0, 6);
        push_done("terminate");
        drain("terminate");

        // Reset in the middle of a dash: key drops, no Done
        issue(10'b0111111111, 1'b0);
        push("reset_mid", 1'b0, 1'b1, 1'b0, 5);
        push("reset_mid", 1'b1, 1'b0, 1'b0, 4);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drain("reset_mid");

        // Clean restart after reset
        issue(10'b0011111111, 1'b0);
        push("after_reset", 1'b0, 1'b1, 1'b0, 2);
        push("after_reset", 1'b0, 1'b0, 1'b0, 6);
        push_done("after_reset");
        drain("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
